// File: rtl/coherence_bus_ctrl.sv
// Memory-side bus and coherence controller for two write-back dcaches.
// Round-robin word arbitration, peer snooping with cache-to-cache forwarding, and write-hit invalidation.
module coherence_bus_ctrl #(
   parameter int WORD_W = 32,
   parameter int ADDR_W = 32
) (
   input  logic                   CLK,
   input  logic                   RST,
   input  logic [1:0]             dREN,
   input  logic [1:0]             dWEN,
   input  logic [1:0][ADDR_W-1:0] daddr,
   input  logic [1:0][WORD_W-1:0] dstore,
   input  logic [1:0]             ccwrite,
   output logic [1:0]             dwait,
   output logic [1:0][WORD_W-1:0] dload,
   output logic [1:0]             ccwait,
   output logic [1:0]             ccinv,
   output logic [1:0][ADDR_W-1:0] ccsnoopaddr,
   output logic                   ramREN,
   output logic                   ramWEN,
   output logic [ADDR_W-1:0]      ramaddr,
   output logic [WORD_W-1:0]      ramstore,
   input  logic [WORD_W-1:0]      ramload,
   input  logic [1:0]             ramstate
);

   // state    | meaning
   // S_IDLE   | arbitrate and latch grant, class and address; no bus activity
   // S_INVAL  | one-cycle invalidate broadcast to the peer
   // S_SNOOP  | one-cycle snoop of the peer; its ccwrite selects C2C or RAM_RD
   // S_C2C    | write forwarded dirty word to RAM, then hand it to the requester
   // S_RAM_RD | word read from RAM for the requester
   // S_RAM_WR | eviction/flush write of the requester's live store data
   typedef enum logic [2:0] {
      S_IDLE,
      S_INVAL,
      S_SNOOP,
      S_C2C,
      S_RAM_RD,
      S_RAM_WR
   } state_t;

   typedef enum logic [1:0] {
      C_RD,
      C_RDX,
      C_WR,
      C_INV
   } cls_t;

   localparam logic [1:0] RAM_ACCESS = 2'd2;

   state_t            r_state;
   state_t            w_next_state;
   cls_t              r_cls;
   cls_t              w_cls;
   logic              r_rr_last;
   logic              r_gnt;
   logic              w_gnt;
   logic              w_peer;
   logic [ADDR_W-1:0] r_addr;
   logic [WORD_W-1:0] r_buf;
   logic [1:0]        w_req;
   logic              w_grant_en;
   logic              w_cap_buf;
   logic              w_ram_done;

   assign w_req      = dREN | dWEN | ccwrite;
   assign w_peer     = ~r_gnt;
   assign w_ram_done = (ramstate == RAM_ACCESS);

   // On a tie the cache that was not granted last wins.
   always_comb begin
      w_gnt = w_req[1];
      if (&w_req) begin
         w_gnt = ~r_rr_last;
      end
      w_cls = C_INV;
      if (dWEN[w_gnt]) begin
         w_cls = C_WR;
      end else if (dREN[w_gnt] && ccwrite[w_gnt]) begin
         w_cls = C_RDX;
      end else if (dREN[w_gnt]) begin
         w_cls = C_RD;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_state   <= S_IDLE;
         r_rr_last <= 1'b1;
         r_gnt     <= 1'b0;
         r_cls     <= C_RD;
         r_addr    <= '0;
         r_buf     <= '0;
      end else begin
         r_state <= w_next_state;
         if (w_grant_en) begin
            r_gnt     <= w_gnt;
            r_rr_last <= w_gnt;
            r_cls     <= w_cls;
            r_addr    <= daddr[w_gnt];
         end
         if (w_cap_buf) begin
            r_buf <= dstore[w_peer];
         end
      end
   end

   always_comb begin
      w_next_state = r_state;
      w_grant_en   = 1'b0;
      w_cap_buf    = 1'b0;
      dwait        = 2'b11;
      dload        = '0;
      ccwait       = '0;
      ccinv        = '0;
      ccsnoopaddr  = '0;
      ramREN       = 1'b0;
      ramWEN       = 1'b0;
      ramaddr      = '0;
      ramstore     = '0;

      case (r_state)
         S_IDLE: begin
            if (|w_req) begin
               w_grant_en = 1'b1;
               case (w_cls)
                  C_INV:   w_next_state = S_INVAL;
                  C_WR:    w_next_state = S_RAM_WR;
                  default: w_next_state = S_SNOOP;
               endcase
            end
         end

         S_INVAL: begin
            ccwait[w_peer]      = 1'b1;
            ccinv[w_peer]       = 1'b1;
            ccsnoopaddr[w_peer] = r_addr;
            w_next_state        = S_IDLE;
         end

         S_SNOOP: begin
            ccwait[w_peer]      = 1'b1;
            ccinv[w_peer]       = (r_cls == C_RDX);
            ccsnoopaddr[w_peer] = r_addr;
            if (ccwrite[w_peer]) begin
               w_cap_buf    = 1'b1;
               w_next_state = S_C2C;
            end else begin
               w_next_state = S_RAM_RD;
            end
         end

         // Requester data always comes from the snoop buffer, RAM only absorbs the write-back.
         S_C2C: begin
            ramWEN   = 1'b1;
            ramaddr  = r_addr;
            ramstore = r_buf;
            if (w_ram_done) begin
               dwait[r_gnt] = 1'b0;
               dload[r_gnt] = r_buf;
               w_next_state = S_IDLE;
            end
         end

         S_RAM_RD: begin
            ramREN  = 1'b1;
            ramaddr = r_addr;
            if (w_ram_done) begin
               dwait[r_gnt] = 1'b0;
               dload[r_gnt] = ramload;
               w_next_state = S_IDLE;
            end
         end

         S_RAM_WR: begin
            ramWEN   = 1'b1;
            ramaddr  = r_addr;
            ramstore = dstore[r_gnt];
            if (w_ram_done) begin
               dwait[r_gnt] = 1'b0;
               w_next_state = S_IDLE;
            end
         end

         default: begin
            w_next_state = S_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_coherence_bus_ctrl.sv
// Scoreboard bench for coherence_bus_ctrl: a transaction-level model predicts snoops,
// RAM accesses and completions in service order; monitors compare what the DUT presents.
module tb_coherence_bus_ctrl;
   localparam int AW = 32;
   localparam int WW = 32;
   localparam int K_RD  = 0;
   localparam int K_RDX = 1;
   localparam int K_WR  = 2;
   localparam int K_INV = 3;

   logic               CLK = 1'b0;
   logic               RST;
   logic [1:0]         dREN, dWEN;
   logic [1:0][AW-1:0] daddr;
   logic [1:0][WW-1:0] drv_dstore, snp_data, dstore;
   logic [1:0]         drv_ccw, snp_ccw, ccwrite;
   logic [1:0]         dwait;
   logic [1:0][WW-1:0] dload;
   logic [1:0]         ccwait, ccinv;
   logic [1:0][AW-1:0] ccsnoopaddr;
   logic               ramREN, ramWEN;
   logic [AW-1:0]      ramaddr;
   logic [WW-1:0]      ramstore, ramload;
   logic [1:0]         ramstate;

   assign ccwrite = drv_ccw | snp_ccw;
   assign dstore  = {(snp_ccw[1] ? snp_data[1] : drv_dstore[1]),
                     (snp_ccw[0] ? snp_data[0] : drv_dstore[0])};

   coherence_bus_ctrl #(.WORD_W(WW), .ADDR_W(AW)) dut (
      .CLK(CLK), .RST(RST), .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
      .ccwrite(ccwrite), .dwait(dwait), .dload(dload), .ccwait(ccwait), .ccinv(ccinv),
      .ccsnoopaddr(ccsnoopaddr), .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr),
      .ramstore(ramstore), .ramload(ramload), .ramstate(ramstate)
   );

   always #5 CLK = ~CLK;

   typedef struct { int tgt; logic [AW-1:0] addr; bit inv; } snp_t;
   typedef struct { bit we; logic [AW-1:0] addr; logic [WW-1:0] data; } ram_t;
   typedef struct { int cache; bit chk; logic [WW-1:0] data; } done_t;
   typedef struct { bit dirty; logic [WW-1:0] data; } rsp_t;

   snp_t  exp_snp[$];
   ram_t  exp_ram[$];
   done_t exp_done[$];
   rsp_t  rsp_q0[$];
   rsp_t  rsp_q1[$];

   logic [WW-1:0] ref_mem [logic [AW-1:0]];
   logic [WW-1:0] ram_mem [logic [AW-1:0]];
   int rr_last_m;
   int checks = 0;
   int errors = 0;
   int lat = 0;
   bit err_mode = 1'b0;
   int cnt = 0;

   function automatic logic [WW-1:0] init_val(input logic [AW-1:0] a);
      return a ^ 32'h5A5A_0000;
   endfunction

   function automatic logic [WW-1:0] rd_ref(input logic [AW-1:0] a);
      return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
   endfunction

   function automatic logic [WW-1:0] rd_ram(input logic [AW-1:0] a);
      return ram_mem.exists(a) ? ram_mem[a] : init_val(a);
   endfunction

   // Transaction-level reference: what the bus must do for one granted request.
   function automatic void model(input int i, input int k, input logic [AW-1:0] a,
                                 input logic [WW-1:0] wd, input bit dirty, input logic [WW-1:0] sd);
      int j = 1 - i;
      rsp_t r;
      r.dirty = (k == K_RD || k == K_RDX) ? dirty : 1'b0;
      r.data  = sd;
      if (k == K_WR) begin
         exp_ram.push_back('{1'b1, a, wd});
         ref_mem[a] = wd;
         exp_done.push_back('{i, 1'b0, '0});
      end else begin
         exp_snp.push_back('{j, a, (k != K_RD)});
         if (j == 0) rsp_q0.push_back(r); else rsp_q1.push_back(r);
         if (k != K_INV) begin
            if (r.dirty) begin
               exp_ram.push_back('{1'b1, a, sd});
               ref_mem[a] = sd;
               exp_done.push_back('{i, 1'b1, sd});
            end else begin
               exp_ram.push_back('{1'b0, a, '0});
               exp_done.push_back('{i, 1'b1, rd_ref(a)});
            end
         end
      end
      rr_last_m = i;
   endfunction

   function automatic rsp_t get_rsp(input int j);
      rsp_t r;
      r.dirty = 1'b0;
      r.data  = '0;
      if (j == 0 && rsp_q0.size() > 0) r = rsp_q0.pop_front();
      if (j == 1 && rsp_q1.size() > 0) r = rsp_q1.pop_front();
      return r;
   endfunction

   // Peer-cache snoop answers and RAM model, driven just after each rising edge.
   initial begin
      rsp_t r;
      snp_ccw  = '0;
      snp_data = '0;
      ramstate = 2'd0;
      ramload  = '0;
      forever begin
         @(posedge CLK);
         #1;
         for (int j = 0; j < 2; j++) begin
            if (ccwait[j]) begin
               r = get_rsp(j);
               snp_ccw[j]  = r.dirty;
               snp_data[j] = r.data;
            end else begin
               snp_ccw[j] = 1'b0;
            end
         end
         if (ramREN || ramWEN) begin
            cnt++;
            if (cnt > lat) begin
               ramstate = 2'd2;
               ramload  = ramREN ? rd_ram(ramaddr) : $urandom;
            end else begin
               ramstate = err_mode ? 2'd3 : 2'($urandom_range(0, 3) == 0 ? 3 : 1);
               ramload  = $urandom;
            end
         end else begin
            cnt      = 0;
            ramstate = 2'd0;
            ramload  = $urandom;
         end
      end
   end

   // Monitor: compares every snoop, completion and RAM access against the scoreboard.
   initial begin
      snp_t  s;
      done_t d;
      ram_t  m;
      forever begin
         @(negedge CLK);
         if (!RST) begin
            for (int j = 0; j < 2; j++) begin
               if (ccwait[j]) begin
                  checks++;
                  if (exp_snp.size() == 0) begin
                     errors++;
                     $display("FAIL snoop_unexpected: cache %0d addr %h", j, ccsnoopaddr[j]);
                  end else begin
                     s = exp_snp.pop_front();
                     if (s.tgt != j || s.addr != ccsnoopaddr[j] || s.inv != ccinv[j]) begin
                        errors++;
                        $display("FAIL snoop: got tgt=%0d addr=%h inv=%0d, want tgt=%0d addr=%h inv=%0d",
                                 j, ccsnoopaddr[j], ccinv[j], s.tgt, s.addr, s.inv);
                     end
                  end
               end
            end
            for (int i = 0; i < 2; i++) begin
               if (!dwait[i]) begin
                  checks++;
                  if (exp_done.size() == 0) begin
                     errors++;
                     $display("FAIL done_unexpected: cache %0d dload %h", i, dload[i]);
                  end else begin
                     d = exp_done.pop_front();
                     if (d.cache != i || (d.chk && dload[i] != d.data)) begin
                        errors++;
                        $display("FAIL done: got cache=%0d dload=%h, want cache=%0d dload=%h",
                                 i, dload[i], d.cache, d.data);
                     end
                  end
               end
            end
            if (ramstate == 2'd2) begin
               checks++;
               if (exp_ram.size() == 0) begin
                  errors++;
                  $display("FAIL ram_unexpected: ren=%0d wen=%0d addr=%h", ramREN, ramWEN, ramaddr);
               end else begin
                  m = exp_ram.pop_front();
                  if (ramWEN != m.we || ramREN != !m.we || ramaddr != m.addr ||
                      (m.we && ramstore != m.data)) begin
                     errors++;
                     $display("FAIL ram: got ren=%0d wen=%0d addr=%h store=%h, want we=%0d addr=%h store=%h",
                              ramREN, ramWEN, ramaddr, ramstore, m.we, m.addr, m.data);
                  end
               end
               if (ramWEN) ram_mem[ramaddr] = ramstore;
            end
         end
      end
   end

   task automatic drive(input int i, input int k, input logic [AW-1:0] a, input logic [WW-1:0] wd);
      dREN[i]       = (k == K_RD || k == K_RDX);
      dWEN[i]       = (k == K_WR);
      drv_ccw[i]    = (k == K_RDX || k == K_INV);
      daddr[i]      = a;
      drv_dstore[i] = wd;
   endtask

   task automatic release_req(input int i);
      dREN[i]    = 1'b0;
      dWEN[i]    = 1'b0;
      drv_ccw[i] = 1'b0;
   endtask

   // Holds each masked request until it is served, then drops it after that edge.
   task automatic wait_done(input bit [1:0] mask, input int k0, input int k1, output int cyc);
      bit [1:0] pend = mask;
      bit [1:0] drop;
      int n = 0;
      int kk;
      while (pend != 2'b00 && n < 300) begin
         @(negedge CLK);
         n++;
         drop = 2'b00;
         for (int i = 0; i < 2; i++) begin
            kk = (i == 0) ? k0 : k1;
            if (pend[i] && ((kk == K_INV) ? ccwait[1-i] : !dwait[i])) begin
               pend[i] = 1'b0;
               drop[i] = 1'b1;
            end
         end
         @(posedge CLK);
         #1;
         for (int i = 0; i < 2; i++) if (drop[i]) release_req(i);
      end
      checks++;
      if (pend != 2'b00) begin
         errors++;
         $display("FAIL timeout: pending mask %b after %0d cycles, want 00", pend, n);
         release_req(0);
         release_req(1);
      end
      cyc = n;
   endtask

   task automatic single(input int i, input int k, input logic [AW-1:0] a, input logic [WW-1:0] wd,
                         input bit dirty, input logic [WW-1:0] sd, input int l);
      int cyc;
      int want;
      lat = l;
      model(i, k, a, wd, dirty, sd);
      drive(i, k, a, wd);
      wait_done(2'b01 << i, k, k, cyc);
      want = (k == K_INV) ? 2 : (k == K_WR) ? 2 + l : 3 + l;
      checks++;
      if (cyc != want) begin
         errors++;
         $display("FAIL latency: cache %0d kind %0d took %0d cycles, want %0d", i, k, cyc, want);
      end
   endtask

   task automatic pair(input int k0, input logic [AW-1:0] a0, input logic [WW-1:0] wd0,
                       input int k1, input logic [AW-1:0] a1, input logic [WW-1:0] wd1, input int l);
      int cyc;
      int w = (rr_last_m == 1) ? 0 : 1;
      lat = l;
      if (w == 0) begin
         model(0, k0, a0, wd0, 1'b0, '0);
         model(1, k1, a1, wd1, 1'b0, '0);
      end else begin
         model(1, k1, a1, wd1, 1'b0, '0);
         model(0, k0, a0, wd0, 1'b0, '0);
      end
      drive(0, k0, a0, wd0);
      drive(1, k1, a1, wd1);
      wait_done(2'b11, k0, k1, cyc);
   endtask

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not finish, want completion");
      $fatal(1, "global timeout");
   end

   initial begin
      int n;
      int k, i;
      logic [AW-1:0] a, a1;
      RST = 1'b1;
      dREN = '0; dWEN = '0; drv_ccw = '0; daddr = '0; drv_dstore = '0;
      rr_last_m = 1;
      ref_mem[32'h40] = 32'hCAFE_F00D;
      ram_mem[32'h40] = 32'hCAFE_F00D;
      repeat (3) @(posedge CLK);
      @(negedge CLK);
      checks += 6;
      if (dwait != 2'b11) begin errors++; $display("FAIL rst_dwait: got %b want 11", dwait); end
      if (dload != '0) begin errors++; $display("FAIL rst_dload: got %h want 0", dload); end
      if (ccwait != 2'b00 || ccinv != 2'b00) begin
         errors++; $display("FAIL rst_cc: got ccwait=%b ccinv=%b want 00 00", ccwait, ccinv);
      end
      if (ccsnoopaddr != '0) begin errors++; $display("FAIL rst_snpaddr: got %h want 0", ccsnoopaddr); end
      if (ramREN || ramWEN) begin errors++; $display("FAIL rst_strobe: got ren=%0d wen=%0d want 0 0", ramREN, ramWEN); end
      if (ramaddr != '0 || ramstore != '0) begin
         errors++; $display("FAIL rst_ram: got addr=%h store=%h want 0 0", ramaddr, ramstore);
      end
      @(posedge CLK);
      #1;
      RST = 1'b0;

      // Simultaneous writes: cache0 wins the first tie out of reset.
      pair(K_WR, 32'h500, 32'h1111_0000, K_WR, 32'h504, 32'h2222_0000, 1);
      single(0, K_WR, 32'h508, 32'h3333_0000, 1'b0, '0, 0);
      pair(K_WR, 32'h50C, 32'h4444_0000, K_WR, 32'h510, 32'h5555_0000, 0);

      single(0, K_RD, 32'h40, '0, 1'b0, '0, 2);
      single(1, K_RD, 32'h80, '0, 1'b1, 32'h1234_5678, 1);
      single(0, K_RDX, 32'h100, '0, 1'b0, '0, 1);
      single(0, K_INV, 32'h200, '0, 1'b0, '0, 0);

      // Reset in the middle of a RAM read aborts it without a completion.
      lat = 10;
      model(0, K_RD, 32'h300, '0, 1'b0, '0);
      drive(0, K_RD, 32'h300, '0);
      n = 0;
      do begin @(negedge CLK); n++; end while (!ramREN && n < 20);
      @(posedge CLK);
      #1;
      RST = 1'b1;
      release_req(0);
      @(posedge CLK);
      @(negedge CLK);
      checks += 2;
      if (ramREN || ramWEN) begin errors++; $display("FAIL abort_strobe: got ren=%0d wen=%0d want 0 0", ramREN, ramWEN); end
      if (dwait != 2'b11) begin errors++; $display("FAIL abort_dwait: got %b want 11", dwait); end
      exp_ram.delete();
      exp_done.delete();
      @(posedge CLK);
      #1;
      RST = 1'b0;
      rr_last_m = 1;
      err_mode = 1'b1;
      single(0, K_RD, 32'h300, '0, 1'b0, '0, 3);
      err_mode = 1'b0;

      for (int t = 0; t < 60; t++) begin
         a  = 32'($urandom_range(1, 8)) << 6;
         a1 = 32'($urandom_range(1, 8)) << 6;
         if ($urandom_range(0, 9) < 7) begin
            i = $urandom_range(0, 1);
            k = $urandom_range(0, 3);
            single(i, k, a, $urandom, 1'($urandom_range(0, 1)), $urandom, $urandom_range(0, 3));
         end else begin
            k = $urandom_range(0, 1) ? K_RD : K_WR;
            pair(k, a, $urandom, ($urandom_range(0, 1) ? K_RD : K_WR), a1, $urandom,
                 $urandom_range(0, 2));
         end
      end

      repeat (4) @(posedge CLK);
      checks++;
      if (exp_snp.size() != 0 || exp_ram.size() != 0 || exp_done.size() != 0) begin
         errors++;
         $display("FAIL leftover: snoop=%0d ram=%0d done=%0d outstanding, want 0 0 0",
                  exp_snp.size(), exp_ram.size(), exp_done.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
